noc_output_arbiter: RTL and testbench
=====================================

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

Interface
REQ-001 Parameter: N_REQ, default 5; number of requesters, fixed at 5 (index 0=N, 1=E, 2=W, 3=S, 4=L).
REQ-002 Port: clk, input, 1; single clock, all logic on posedge clk.
REQ-003 Port: rst, input, 1; reset, synchronous, active-low (rst=0 resets on posedge clk).
REQ-004 Port: req, input, 5; req[i]=1: input port i's route logic selects this output.
REQ-005 Port: valid, input, 5; valid[i]=1: input FIFO i non-empty (inverse of empty).
REQ-006 Port: flit_id, input, 15; flit_id[3i+2:3i] = head-flit type of FIFO i (one-hot: 001 header, 010 payload, 100 tail).
REQ-007 Port: out_ready, input, 1; downstream can accept one flit this cycle.
REQ-008 Port: grant, output, 5; registered one-hot owner of this output, 0 when free.
REQ-009 Port: read_en, output, 5; combinational pop strobe to FIFO i, at most one bit set.
REQ-010 Port: xbar_sel, output, 3; binary index of granted requester, 0 when free.
REQ-011 Port: out_valid, output, 1; flit forwarded this cycle (= |read_en).
REQ-012 Port: err, output, 1; sticky protocol-error flag.

Function
REQ-013 Two states: IDLE (grant=0) and BUSY (exactly one grant bit set); state, grant, pointer and err are registers.
REQ-014 Eligible(i) = req[i] & valid[i] & (flit_id_i == 001).
REQ-015 IDLE: if any requester is eligible, the winner is the first eligible index searching from ptr+1 upward modulo 5; next cycle grant=onehot(winner), xbar_sel=winner, state BUSY.
REQ-016 IDLE with no eligible requester: stay IDLE, grant=0, read_en=0.
REQ-017 No flit is popped in the arbitration cycle; first pop is no earlier than one cycle after the header becomes eligible.
REQ-018 BUSY, owner g: read_en[g] = valid[g] & out_ready; all other read_en bits 0.
REQ-019 BUSY: req of the owner and req/valid of others are ignored; no preemption.
REQ-020 BUSY: a pop with flit_id_g == 100 (tail) releases: next cycle grant=0, state IDLE, ptr=g.
REQ-021 BUSY: a pop with flit_id_g == 010 keeps the grant; valid[g]=0 or out_ready=0 stalls with grant held indefinitely.
REQ-022 BUSY: a pop with flit_id_g == 001 (header inside packet) or a non-one-hot value sets err=1; the flit is forwarded and the grant held.
REQ-023 IDLE: a non-one-hot flit_id on a requester with req&valid sets err=1; that requester is not eligible.
REQ-024 err is cleared only by reset.
REQ-025 Minimum gap between packets on this output: one idle cycle (release cycle -> IDLE arbitration -> BUSY).
REQ-026 Pointer update happens only on release, so the releasing requester gets lowest priority in the next arbitration.

Reset
REQ-027 rst=0 at posedge: state=IDLE, grant=0, xbar_sel=0, err=0, ptr=4 (requester 0 wins first); read_en=0 and out_valid=0 while rst=0.
REQ-028 Reset mid-packet aborts the packet immediately with no pop in the reset cycle; the partial packet is not resumed.

Verification
REQ-029 Single requester: req=00001, valid=1, 3-flit packet (001,010,100), out_ready=1 -> grant=00001 at cycle+1, read_en[0] pulses 3 consecutive cycles, grant=0 after the tail, ptr=0.
REQ-030 Round-robin: all 5 requesting headers continuously after reset -> grant order 0,1,2,3,4,0, each packet completed before the next grant.
REQ-031 Lock/no preemption: owner 2 mid-packet, requester 1 raises a header -> grant stays 00100 until the tail pops, then 00010 after one IDLE cycle.
REQ-032 Backpressure/bubbles: out_ready=0 for 4 cycles, then valid[g]=0 for 2 cycles mid-packet -> read_en=0 during both, grant held, no flit lost or duplicated.
REQ-033 Protocol error: owner's head shows 001 during BUSY -> err=1 sticky, packet continues, err stays 1 until rst=0.
REQ-034 Reset mid-operation: rst=0 during a BUSY payload -> next cycle grant=0, ptr=4, err=0, read_en=0 throughout reset.

Source files
------------

// File: rtl/noc_output_arbiter.sv
// Round-robin wormhole arbiter for one router output port: locks the output to a
// single input from header to tail and forwards that input's flits when downstream is ready.
module noc_output_arbiter #(
    parameter int N_REQ = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     valid,
    input  logic [3*N_REQ-1:0]   flit_id,
    input  logic                 out_ready,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     read_en,
    output logic [2:0]           xbar_sel,
    output logic                 out_valid,
    output logic                 err
);

    localparam logic [2:0] FLIT_HEAD    = 3'b001;
    localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
    localparam logic [2:0] FLIT_TAIL    = 3'b100;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t             state, state_next;
    logic [N_REQ-1:0]   grant_next;
    logic [2:0]         owner, owner_next;
    logic [2:0]         ptr, ptr_next;
    logic               hdr_done, hdr_done_next;
    logic               err_next;

    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   malformed;
    logic [2:0]         owner_fid;
    logic               owner_valid;
    logic               pop;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == FLIT_HEAD) || (v == FLIT_PAYLOAD) || (v == FLIT_TAIL);
    endfunction

    always_comb begin
        eligible  = '0;
        malformed = '0;
        for (int i = 0; i < N_REQ; i++) begin
            eligible[i]  = req[i] & valid[i] & (flit_id[3*i +: 3] == FLIT_HEAD);
            malformed[i] = req[i] & valid[i] & ~is_onehot3(flit_id[3*i +: 3]);
        end
    end

    always_comb begin
        owner_fid   = '0;
        owner_valid = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == 3'(i)) begin
                owner_fid   = flit_id[3*i +: 3];
                owner_valid = valid[i];
            end
        end
    end

    // A pop is suppressed while reset is asserted so an aborted packet loses no flit.
    assign pop       = rst && (state == BUSY) && owner_valid && out_ready;
    assign read_en   = pop ? grant : '0;
    assign out_valid = |read_en;
    assign xbar_sel  = (state == BUSY) ? owner : 3'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= 3'd0;
            ptr      <= 3'(N_REQ - 1);
            hdr_done <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_next;
            grant    <= grant_next;
            owner    <= owner_next;
            ptr      <= ptr_next;
            hdr_done <= hdr_done_next;
            err      <= err_next;
        end
    end

    always_comb begin
        int  cand;
        int  win;
        logic found;

        state_next    = state;
        grant_next    = grant;
        owner_next    = owner;
        ptr_next      = ptr;
        hdr_done_next = hdr_done;
        err_next      = err;
        cand          = 0;
        win           = 0;
        found         = 1'b0;

        case (state)
            IDLE: begin
                if (|malformed) begin
                    err_next = 1'b1;
                end
                for (int k = 1; k <= N_REQ; k++) begin
                    cand = int'(ptr) + k;
                    if (cand >= N_REQ) begin
                        cand = cand - N_REQ;
                    end
                    if (!found && eligible[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                end
                if (found) begin
                    state_next      = BUSY;
                    grant_next      = '0;
                    grant_next[win] = 1'b1;
                    owner_next      = 3'(win);
                    hdr_done_next   = 1'b0;
                end
            end
            BUSY: begin
                // The first pop of a packet is its own header; any later header is a protocol error.
                if (pop) begin
                    if (!hdr_done) begin
                        hdr_done_next = 1'b1;
                        if (owner_fid != FLIT_HEAD) begin
                            err_next = 1'b1;
                        end
                    end else begin
                        case (owner_fid)
                            FLIT_TAIL: begin
                                state_next = IDLE;
                                grant_next = '0;
                                ptr_next   = owner;
                            end
                            FLIT_PAYLOAD: ;
                            default: err_next = 1'b1;
                        endcase
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed-vector bench for noc_output_arbiter: arbitration order, wormhole lock,
// backpressure, protocol errors and reset abort, all with hand-computed expectations.
module tb_noc_output_arbiter;

    localparam logic [2:0] H = 3'b001;
    localparam logic [2:0] P = 3'b010;
    localparam logic [2:0] T = 3'b100;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [4:0]  valid;
    logic [14:0] flit_id;
    logic        out_ready;
    logic [4:0]  grant;
    logic [4:0]  read_en;
    logic [2:0]  xbar_sel;
    logic        out_valid;
    logic        err;

    int vectors;
    int miscompares;

    noc_output_arbiter #(.N_REQ(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .valid     (valid),
        .flit_id   (flit_id),
        .out_ready (out_ready),
        .grant     (grant),
        .read_en   (read_en),
        .xbar_sel  (xbar_sel),
        .out_valid (out_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] pack(input logic [2:0] f4, input logic [2:0] f3,
                                         input logic [2:0] f2, input logic [2:0] f1,
                                         input logic [2:0] f0);
        return {f4, f3, f2, f1, f0};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of posedge.
    task automatic applyStimulus(input logic r, input logic [4:0] rq, input logic [4:0] vl,
                                 input logic [14:0] fid, input logic ordy);
        @(negedge clk);
        rst       = r;
        req       = rq;
        valid     = vl;
        flit_id   = fid;
        out_ready = ordy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] exp_grant,
                               input logic [4:0] exp_read_en, input logic [2:0] exp_xbar,
                               input logic exp_err);
        vectors++;
        assert (grant === exp_grant) else begin
            miscompares++;
            $error("[TB] FAIL %s grant observed=%b expected=%b", tag, grant, exp_grant);
        end
        vectors++;
        assert (read_en === exp_read_en) else begin
            miscompares++;
            $error("[TB] FAIL %s read_en observed=%b expected=%b", tag, read_en, exp_read_en);
        end
        vectors++;
        assert (xbar_sel === exp_xbar) else begin
            miscompares++;
            $error("[TB] FAIL %s xbar_sel observed=%0d expected=%0d", tag, xbar_sel, exp_xbar);
        end
        vectors++;
        assert (out_valid === (|exp_read_en)) else begin
            miscompares++;
            $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, |exp_read_en);
        end
        vectors++;
        assert (err === exp_err) else begin
            miscompares++;
            $error("[TB] FAIL %s err observed=%b expected=%b", tag, err, exp_err);
        end
    endtask

    initial begin
        logic [14:0] all_h;
        logic [14:0] fid_t;
        logic [4:0]  oh;
        int          w;
        int          rr_order [6];

        vectors     = 0;
        miscompares = 0;
        all_h       = {5{H}};
        rr_order    = '{0, 1, 2, 3, 4, 0};

        rst       = 1'b0;
        req       = 5'b11111;
        valid     = 5'b11111;
        flit_id   = all_h;
        out_ready = 1'b1;

        applyStimulus(1'b0, 5'b11111, 5'b11111, all_h, 1'b1);
        checkOutput("reset", 5'b00000, 5'b00000, 3'd0, 1'b0);

        // Single requester, 3-flit packet
        applyStimulus(1'b1, 5'b00001, 5'b00001, all_h, 1'b1);
        checkOutput("single_arb", 5'b00000, 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00001, 5'b00001, all_h, 1'b1);
        checkOutput("single_head", 5'b00001, 5'b00001, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00001, 5'b00001, pack(H, H, H, H, P), 1'b1);
        checkOutput("single_pay", 5'b00001, 5'b00001, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00001, 5'b00001, pack(H, H, H, H, T), 1'b1);
        checkOutput("single_tail", 5'b00001, 5'b00001, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00000, 5'b00000, all_h, 1'b1);
        checkOutput("single_free", 5'b00000, 5'b00000, 3'd0, 1'b0);

        // Round-robin with all five requesters holding headers after reset
        applyStimulus(1'b0, 5'b11111, 5'b11111, all_h, 1'b1);
        checkOutput("rr_reset", 5'b00000, 5'b00000, 3'd0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            w  = rr_order[k];
            oh = 5'(1 << w);
            applyStimulus(1'b1, 5'b11111, 5'b11111, all_h, 1'b1);
            checkOutput("rr_idle", 5'b00000, 5'b00000, 3'd0, 1'b0);
            applyStimulus(1'b1, 5'b11111, 5'b11111, all_h, 1'b1);
            checkOutput("rr_head", oh, oh, 3'(w), 1'b0);
            fid_t = all_h;
            fid_t[3*w +: 3] = T;
            applyStimulus(1'b1, 5'b11111, 5'b11111, fid_t, 1'b1);
            checkOutput("rr_tail", oh, oh, 3'(w), 1'b0);
        end

        // Lock: owner 2 keeps the output while requester 1 waits with a header
        applyStimulus(1'b1, 5'b00100, 5'b00100, all_h, 1'b1);
        checkOutput("lock_arb", 5'b00000, 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00100, 5'b00100, all_h, 1'b1);
        checkOutput("lock_head", 5'b00100, 5'b00100, 3'd2, 1'b0);
        applyStimulus(1'b1, 5'b00110, 5'b00110, pack(H, H, P, H, H), 1'b1);
        checkOutput("lock_pay", 5'b00100, 5'b00100, 3'd2, 1'b0);
        applyStimulus(1'b1, 5'b00110, 5'b00110, pack(H, H, T, H, H), 1'b1);
        checkOutput("lock_tail", 5'b00100, 5'b00100, 3'd2, 1'b0);
        applyStimulus(1'b1, 5'b00010, 5'b00010, all_h, 1'b1);
        checkOutput("lock_gap", 5'b00000, 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00010, 5'b00010, all_h, 1'b1);
        checkOutput("lock_next_head", 5'b00010, 5'b00010, 3'd1, 1'b0);
        applyStimulus(1'b1, 5'b00010, 5'b00010, pack(H, H, H, T, H), 1'b1);
        checkOutput("lock_next_tail", 5'b00010, 5'b00010, 3'd1, 1'b0);

        // Backpressure then source bubbles on owner 3
        applyStimulus(1'b1, 5'b01000, 5'b01000, all_h, 1'b1);
        checkOutput("bp_arb", 5'b00000, 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b01000, 5'b01000, all_h, 1'b1);
        checkOutput("bp_head", 5'b01000, 5'b01000, 3'd3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 5'b01000, 5'b01000, pack(H, P, H, H, H), 1'b0);
            checkOutput("bp_stall", 5'b01000, 5'b00000, 3'd3, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 5'b01000, 5'b00000, pack(H, P, H, H, H), 1'b1);
            checkOutput("bp_bubble", 5'b01000, 5'b00000, 3'd3, 1'b0);
        end
        applyStimulus(1'b1, 5'b01000, 5'b01000, pack(H, P, H, H, H), 1'b1);
        checkOutput("bp_pay", 5'b01000, 5'b01000, 3'd3, 1'b0);
        applyStimulus(1'b1, 5'b01000, 5'b01000, pack(H, T, H, H, H), 1'b1);
        checkOutput("bp_tail", 5'b01000, 5'b01000, 3'd3, 1'b0);
        applyStimulus(1'b1, 5'b00000, 5'b00000, all_h, 1'b1);
        checkOutput("bp_free", 5'b00000, 5'b00000, 3'd0, 1'b0);

        // Header appearing mid-packet on owner 4 raises a sticky error
        applyStimulus(1'b1, 5'b10000, 5'b10000, all_h, 1'b1);
        checkOutput("perr_arb", 5'b00000, 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10000, 5'b10000, all_h, 1'b1);
        checkOutput("perr_head", 5'b10000, 5'b10000, 3'd4, 1'b0);
        applyStimulus(1'b1, 5'b10000, 5'b10000, all_h, 1'b1);
        checkOutput("perr_bad_head", 5'b10000, 5'b10000, 3'd4, 1'b0);
        applyStimulus(1'b1, 5'b10000, 5'b10000, pack(P, H, H, H, H), 1'b1);
        checkOutput("perr_pay", 5'b10000, 5'b10000, 3'd4, 1'b1);
        applyStimulus(1'b1, 5'b10000, 5'b10000, pack(T, H, H, H, H), 1'b1);
        checkOutput("perr_tail", 5'b10000, 5'b10000, 3'd4, 1'b1);
        applyStimulus(1'b1, 5'b00000, 5'b00000, all_h, 1'b1);
        checkOutput("perr_sticky", 5'b00000, 5'b00000, 3'd0, 1'b1);

        // Move the pointer off 4, then abort a packet from owner 2 with reset
        applyStimulus(1'b1, 5'b00010, 5'b00010, all_h, 1'b1);
        checkOutput("rst_pre_arb", 5'b00000, 5'b00000, 3'd0, 1'b1);
        applyStimulus(1'b1, 5'b00010, 5'b00010, all_h, 1'b1);
        checkOutput("rst_pre_head", 5'b00010, 5'b00010, 3'd1, 1'b1);
        applyStimulus(1'b1, 5'b00010, 5'b00010, pack(H, H, H, T, H), 1'b1);
        checkOutput("rst_pre_tail", 5'b00010, 5'b00010, 3'd1, 1'b1);
        applyStimulus(1'b1, 5'b00100, 5'b00100, all_h, 1'b1);
        checkOutput("rst_arb", 5'b00000, 5'b00000, 3'd0, 1'b1);
        applyStimulus(1'b1, 5'b00100, 5'b00100, all_h, 1'b1);
        checkOutput("rst_head", 5'b00100, 5'b00100, 3'd2, 1'b1);
        applyStimulus(1'b0, 5'b00100, 5'b00100, pack(H, H, P, H, H), 1'b1);
        checkOutput("rst_assert", 5'b00100, 5'b00000, 3'd2, 1'b1);
        applyStimulus(1'b0, 5'b00100, 5'b00100, pack(H, H, P, H, H), 1'b1);
        checkOutput("rst_held", 5'b00000, 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10101, 5'b10101, pack(H, H, P, H, H), 1'b1);
        checkOutput("rst_post_arb", 5'b00000, 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10101, 5'b10101, pack(H, H, P, H, H), 1'b1);
        checkOutput("rst_post_head", 5'b00001, 5'b00001, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b10101, 5'b10101, pack(H, H, P, H, T), 1'b1);
        checkOutput("rst_post_tail", 5'b00001, 5'b00001, 3'd0, 1'b0);

        // Malformed head type in IDLE flags an error and is not granted
        applyStimulus(1'b1, 5'b00010, 5'b00010, pack(H, H, H, 3'b011, H), 1'b1);
        checkOutput("idle_bad_arb", 5'b00000, 5'b00000, 3'd0, 1'b0);
        applyStimulus(1'b1, 5'b00000, 5'b00000, all_h, 1'b1);
        checkOutput("idle_bad_flag", 5'b00000, 5'b00000, 3'd0, 1'b1);
        applyStimulus(1'b1, 5'b00000, 5'b00000, all_h, 1'b1);
        checkOutput("idle_bad_sticky", 5'b00000, 5'b00000, 3'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
